// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
// Instruction field positions, multi-cycle opcodes, FSM encoding and control bundle.
package pipe_pkg;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 26;
  localparam int unsigned RS_HI  = 25;
  localparam int unsigned RS_LO  = 21;
  localparam int unsigned RT_HI  = 20;
  localparam int unsigned RT_LO  = 16;
  localparam int unsigned RD_HI  = 15;
  localparam int unsigned RD_LO  = 11;

  localparam int unsigned OPC_W = OPC_HI - OPC_LO + 1;
  localparam int unsigned REG_W = RS_HI - RS_LO + 1;

  localparam logic [OPC_W-1:0] OP_MUL = 6'b011000;
  localparam logic [OPC_W-1:0] OP_DIV = 6'b011001;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_BUSY  = 2'd1,
    BR_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic fd_flush;
    logic de_en;
    logic de_flush;
    logic ex_hold;
  } ctrl_t;

  function automatic logic is_multicycle(input logic [OPC_W-1:0] opc);
    return (opc == OP_MUL) || (opc == OP_DIV);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard terms: load-use (lu), taken branch (br), multi-cycle op in decode (mc).
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              dec_valid,
  input  logic [DWIDTH-1:0] dec_inst,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              br_taken,
  output logic              lu,
  output logic              br,
  output logic              mc
);

  logic [OPC_W-1:0] opc;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic             unused_inst_bits;

  assign opc = dec_inst[OPC_HI:OPC_LO];
  assign rs  = dec_inst[RS_HI:RS_LO];
  assign rt  = dec_inst[RT_HI:RT_LO];

  // rd and the immediate/function bits play no part in hazard detection
  assign unused_inst_bits = ^dec_inst[RD_HI:0];

  // rt is compared even for instructions that do not read it (conservative)
  assign lu = ex_valid & ex_is_load & (ex_rd != REG_W'(0)) & dec_valid &
              ((rs == ex_rd) | (rt == ex_rd));
  assign br = ex_valid & br_taken;
  assign mc = dec_valid & is_multicycle(opc);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and sequencing controller: load-use bubbles, multi-cycle holds, branch squash.
// Optional performance counters are enabled with the PIPE_PERF_CNT_EN macro.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned MC_LAT     = 4,
  parameter int unsigned BR_PENALTY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [DWIDTH-1:0] dec_inst,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              br_taken,
  output logic              pc_en,
  output logic              fd_en,
  output logic              fd_flush,
  output logic              de_en,
  output logic              de_flush,
  output logic              ex_hold
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events
`endif
);

  localparam int unsigned MAXC = (MC_LAT > BR_PENALTY) ? MC_LAT : BR_PENALTY;
  localparam int unsigned CW   = (MAXC > 2) ? $clog2(MAXC) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lu;
  logic          br;
  logic          mc;
  ctrl_t         ctrl;

  hazard_detect #(
    .DWIDTH(DWIDTH)
  ) u_hazard (
    .dec_valid (dec_valid),
    .dec_inst  (dec_inst),
    .ex_valid  (ex_valid),
    .ex_is_load(ex_is_load),
    .ex_rd     (ex_rd),
    .br_taken  (br_taken),
    .lu        (lu),
    .br        (br),
    .mc        (mc)
  );

  // State and down-counter; both busy states return to RUN when cnt reaches 1
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (br) begin
            if (BR_PENALTY > 1) begin
              state <= BR_FLUSH;
              cnt   <= CW'(BR_PENALTY - 1);
            end
          end else if (!lu && mc) begin
            state <= MC_BUSY;
            cnt   <= CW'(MC_LAT - 1);
          end
        end
        MC_BUSY, BR_FLUSH: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Zero-latency control decode; br outranks lu outranks mc in RUN
  always_comb begin
    ctrl = '{pc_en: 1'b1, fd_en: 1'b1, fd_flush: 1'b0,
             de_en: 1'b1, de_flush: 1'b0, ex_hold: 1'b0};
    if (!rst) begin
      ctrl = '{pc_en: 1'b0, fd_en: 1'b0, fd_flush: 1'b1,
               de_en: 1'b0, de_flush: 1'b1, ex_hold: 1'b0};
    end else begin
      case (state)
        RUN: begin
          if (br) begin
            ctrl.fd_flush = 1'b1;
            ctrl.de_flush = 1'b1;
          end else if (lu) begin
            ctrl.pc_en    = 1'b0;
            ctrl.fd_en    = 1'b0;
            ctrl.de_flush = 1'b1;
          end
        end
        MC_BUSY: begin
          ctrl.pc_en   = 1'b0;
          ctrl.fd_en   = 1'b0;
          ctrl.de_en   = 1'b0;
          ctrl.ex_hold = 1'b1;
        end
        BR_FLUSH: begin
          ctrl.fd_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_en    = ctrl.pc_en;
  assign fd_en    = ctrl.fd_en;
  assign fd_flush = ctrl.fd_flush;
  assign de_en    = ctrl.de_en;
  assign de_flush = ctrl.de_flush;
  assign ex_hold  = ctrl.ex_hold;

`ifdef PIPE_PERF_CNT_EN
  // Stall cycles and accepted branches; both wrap naturally at 2^32
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!ctrl.pc_en) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if ((state == RUN) && br) begin
        flush_events <= flush_events + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl (MC_LAT = 4, BR_PENALTY = 2).
// Expected control vectors are queued as stimulus is applied and checked mid-cycle.
module tb_pipe_ctrl;

  localparam logic [5:0] OP_MUL = 6'b011000;
  localparam logic [5:0] OP_DIV = 6'b011001;
  localparam logic [5:0] OP_ALU = 6'b000000;

  // {pc_en, fd_en, fd_flush, de_en, de_flush, ex_hold}
  localparam logic [5:0] E_RST  = 6'b001010;
  localparam logic [5:0] E_NORM = 6'b110100;
  localparam logic [5:0] E_LU   = 6'b000110;
  localparam logic [5:0] E_BR   = 6'b111110;
  localparam logic [5:0] E_BRF  = 6'b111100;
  localparam logic [5:0] E_HOLD = 6'b000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic        ex_valid;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        br_taken;
  logic        pc_en, fd_en, fd_flush, de_en, de_flush, ex_hold;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
  int unsigned stall_exp = 0;
  int unsigned flush_exp = 0;
`endif

  logic [5:0] exp_q[$];
  string      tag_q[$];
  int         checks = 0;
  int         passes = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .DWIDTH    (32),
    .MC_LAT    (4),
    .BR_PENALTY(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dec_valid (dec_valid),
    .dec_inst  (dec_inst),
    .ex_valid  (ex_valid),
    .ex_is_load(ex_is_load),
    .ex_rd     (ex_rd),
    .br_taken  (br_taken),
    .pc_en     (pc_en),
    .fd_en     (fd_en),
    .fd_flush  (fd_flush),
    .de_en     (de_en),
    .de_flush  (de_flush),
    .ex_hold   (ex_hold)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
`endif
  );

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt);
    return {op, rs, rt, 5'd9, 11'h0a5};
  endfunction

  task automatic check_out();
    logic [5:0] obs;
    logic [5:0] e;
    string      t;
    obs = {pc_en, fd_en, fd_flush, de_en, de_flush, ex_hold};
    checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%b expected=<entry>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) passes++;
      else $error("FAIL %s observed=%b expected=%b", t, obs, e);
    end
  endtask

  // One cycle: drive after the edge, enqueue the expectation, compare at the falling edge
  task automatic step(input logic r, input logic dv, input logic [31:0] inst,
                      input logic ev, input logic ld, input logic [4:0] rd,
                      input logic bt, input logic [5:0] e, input string t);
    @(posedge clk);
    #1;
    rst = r; dec_valid = dv; dec_inst = inst;
    ex_valid = ev; ex_is_load = ld; ex_rd = rd; br_taken = bt;
    exp_q.push_back(e);
    tag_q.push_back(t);
`ifdef PIPE_PERF_CNT_EN
    if (!r) begin
      stall_exp = 0;
      flush_exp = 0;
    end else begin
      if (!e[5]) stall_exp++;
      if (e == E_BR) flush_exp++;
    end
`endif
    @(negedge clk);
    check_out();
  endtask

  task automatic idle(input logic [5:0] e, input string t);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, e, t);
  endtask

  initial begin
    rst = 1'b0; dec_valid = 1'b0; dec_inst = '0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = '0; br_taken = 1'b0;

    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'($urandom), 32'($urandom), 1'($urandom), 1'($urandom),
           5'($urandom), 1'($urandom), E_RST, "reset_forced");
    end
    idle(E_NORM, "reset_release");

    // Load-use on rs, then the load leaves execute
    step(1'b1, 1'b1, mk(OP_ALU, 5'd5, 5'd1), 1'b1, 1'b1, 5'd5, 1'b0, E_LU, "lu_rs");
    step(1'b1, 1'b1, mk(OP_ALU, 5'd5, 5'd1), 1'b1, 1'b0, 5'd0, 1'b0, E_NORM, "lu_rs_clear");
    step(1'b1, 1'b1, mk(OP_ALU, 5'd2, 5'd7), 1'b1, 1'b1, 5'd7, 1'b0, E_LU, "lu_rt");
    step(1'b1, 1'b1, mk(OP_ALU, 5'd0, 5'd0), 1'b1, 1'b1, 5'd0, 1'b0, E_NORM, "lu_rd0");
    step(1'b1, 1'b1, mk(OP_ALU, 5'd1, 5'd2), 1'b1, 1'b1, 5'd3, 1'b0, E_NORM, "lu_nomatch");
    step(1'b1, 1'b0, mk(OP_ALU, 5'd4, 5'd4), 1'b1, 1'b1, 5'd4, 1'b0, E_NORM, "lu_dec_invalid");

    // Multi-cycle op: entry cycle, three hold cycles (branch ignored), resume
    step(1'b1, 1'b1, mk(OP_MUL, 5'd1, 5'd2), 1'b0, 1'b0, 5'd0, 1'b0, E_NORM, "mc_enter");
    idle(E_HOLD, "mc_hold1");
    step(1'b1, 1'b1, mk(OP_ALU, 5'd6, 5'd6), 1'b1, 1'b1, 5'd6, 1'b1, E_HOLD, "mc_hold2_ign");
    idle(E_HOLD, "mc_hold3");
    idle(E_NORM, "mc_resume");
    step(1'b1, 1'b0, mk(OP_MUL, 5'd1, 5'd2), 1'b0, 1'b0, 5'd0, 1'b0, E_NORM, "mc_invalid");
    idle(E_NORM, "mc_invalid_next");

    // Taken branch with a second branch during the squash cycle
    step(1'b1, 1'b1, mk(OP_ALU, 5'd1, 5'd2), 1'b1, 1'b0, 5'd0, 1'b1, E_BR, "br_cycle0");
    step(1'b1, 1'b1, mk(OP_ALU, 5'd1, 5'd2), 1'b1, 1'b0, 5'd0, 1'b1, E_BRF, "br_cycle1");
    idle(E_NORM, "br_cycle2");
    step(1'b1, 1'b1, mk(OP_ALU, 5'd1, 5'd2), 1'b0, 1'b0, 5'd0, 1'b1, E_NORM, "br_ex_invalid");

    // Branch beats load-use and a multi-cycle op in decode
    step(1'b1, 1'b1, mk(OP_ALU, 5'd5, 5'd1), 1'b1, 1'b1, 5'd5, 1'b1, E_BR, "br_lu");
    idle(E_BRF, "br_lu_flush");
    idle(E_NORM, "br_lu_done");
    step(1'b1, 1'b1, mk(OP_DIV, 5'd1, 5'd2), 1'b1, 1'b0, 5'd0, 1'b1, E_BR, "br_div");
    idle(E_BRF, "br_div_no_mc");
    idle(E_NORM, "br_div_done");

    // Reset in the middle of MC_BUSY
    step(1'b1, 1'b1, mk(OP_DIV, 5'd1, 5'd2), 1'b0, 1'b0, 5'd0, 1'b0, E_NORM, "mcr_enter");
    idle(E_HOLD, "mcr_hold1");
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, E_RST, "mcr_reset");
    idle(E_NORM, "mcr_after");
    idle(E_NORM, "mcr_after2");

    // Reset in the middle of BR_FLUSH
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1, E_BR, "brr_br");
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, E_RST, "brr_reset");
    idle(E_NORM, "brr_after");

    // Closing activity so the counters see stalls and a branch after the last reset
    step(1'b1, 1'b1, mk(OP_ALU, 5'd3, 5'd1), 1'b1, 1'b1, 5'd3, 1'b0, E_LU, "tail_lu");
    step(1'b1, 1'b1, mk(OP_MUL, 5'd1, 5'd2), 1'b0, 1'b0, 5'd0, 1'b0, E_NORM, "tail_mc");
    idle(E_HOLD, "tail_hold1");
    idle(E_HOLD, "tail_hold2");
    idle(E_HOLD, "tail_hold3");
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1, E_BR, "tail_br");
    idle(E_BRF, "tail_brf");
    idle(E_NORM, "tail_norm");

`ifdef PIPE_PERF_CNT_EN
    @(posedge clk);
    #1;
    checks++;
    assert (stall_cycles === 32'(stall_exp)) passes++;
    else $error("FAIL stall_cycles observed=%0d expected=%0d", stall_cycles, stall_exp);
    checks++;
    assert (flush_events === 32'(flush_exp)) passes++;
    else $error("FAIL flush_events observed=%0d expected=%0d", flush_events, flush_exp);
`endif

    checks++;
    assert (exp_q.size() == 0) passes++;
    else $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Hazard and sequencing controller for the 32-bit in-order processor pipeline. It drives the enable and flush inputs of the PC, the fetch/decode register and the decode/execute register.
- Detects load-use hazards and inserts a one-cycle bubble.
- Holds the pipeline while a multi-cycle ALU op (MUL/DIV) occupies execute.
- Squashes wrong-path instructions after a taken branch.

Parameters:
DWIDTH, 32, instruction width
MC_LAT, 4, total execute cycles of a multi-cycle op (must be >= 2)
BR_PENALTY, 1, cycles of fetch squash after a taken branch (>= 1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low (asserted when 0)
dec_valid  in  1  decode register holds a valid instruction
dec_inst  in  DWIDTH  instruction in decode (opcode [31:26], rs [25:21], rt [20:16], rd [15:11])
ex_valid  in  1  execute stage holds a valid instruction
ex_is_load  in  1  execute instruction is a load
ex_rd  in  5  destination register of the execute instruction
br_taken  in  1  execute resolved a taken branch this cycle
pc_en  out  1  PC update enable
fd_en  out  1  fetch/decode register enable
fd_flush  out  1  load a bubble into fetch/decode
de_en  out  1  decode/execute register enable
de_flush  out  1  load a bubble into decode/execute
ex_hold  out  1  execute stage holds its multi-cycle op

Behaviour:
- FSM states: RUN, MC_BUSY, BR_FLUSH. One down-counter cnt, width clog2(max(MC_LAT, BR_PENALTY)).
- Reset (rst == 0 at posedge): state <= RUN, cnt <= 0.
- While rst == 0, outputs are forced: pc_en = fd_en = de_en = ex_hold = 0, fd_flush = de_flush = 1.
- Outputs are combinational from state, cnt and the inputs. There is zero-cycle latency from hazard to control.
- Hazard terms:
  - lu = ex_valid & ex_is_load & ex_rd != 0 & dec_valid & (rs == ex_rd | rt == ex_rd). The rt compare is conservative and always applied.
  - br = ex_valid & br_taken.
  - mc = dec_valid & opcode in {OP_MUL, OP_DIV}.
- RUN, priority br > lu > mc > none:
  - br: pc_en = 1, fd_en = 1, fd_flush = 1, de_en = 1, de_flush = 1. If BR_PENALTY > 1: go to BR_FLUSH, cnt <= BR_PENALTY-1.
  - lu: pc_en = 0, fd_en = 0, de_en = 1, de_flush = 1. Stay in RUN; the hazard clears once the load leaves execute.
  - mc: all enables 1, no flush (the op advances into execute). Go to MC_BUSY, cnt <= MC_LAT-1.
  - none: all enables 1, flushes 0.
- MC_BUSY:
  - pc_en = fd_en = de_en = 0, flushes 0, ex_hold = 1.
  - cnt decrements each cycle. When cnt == 1, go to RUN.
  - MC_BUSY therefore lasts exactly MC_LAT-1 cycles.
  - br and lu are ignored; the execute op cannot be a branch or a load.
- BR_FLUSH:
  - pc_en = fd_en = de_en = 1, fd_flush = 1, de_flush = 0.
  - cnt decrements; when cnt == 1, go to RUN.
  - A new br is ignored (its execute slot is a bubble).
- Simultaneous br + lu, or br + mc: br wins. The decode instruction is wrong-path, so no stall occurs and MC_BUSY is not entered.
- rd == 0 never creates a hazard.
- Reset asserted in MC_BUSY or BR_FLUSH: the FSM returns to RUN on that edge and the counter clears.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: adds output ports stall_cycles[31:0] and flush_events[31:0], both reset to 0.
  - stall_cycles increments on every cycle with rst == 1 and pc_en == 0.
  - flush_events increments once per accepted br.
  - Both wrap at 2^32.
- Undefined: no ports, no counters.

Decomposition:
- Shared package pipe_pkg:
  - opcode constants OP_MUL = 6'b011000 and OP_DIV = 6'b011001
  - field bit-position constants for opcode, rs, rt and rd
  - state encoding RUN = 2'd0, MC_BUSY = 2'd1, BR_FLUSH = 2'd2
- Sub-module hazard_detect: purely combinational lu/br/mc term generation, instantiated once. FSM and output muxing stay in pipe_ctrl.

Test Plan:
- Reset: rst = 0 for 2 cycles with random inputs -> pc_en = 0, fd_flush = de_flush = 1. Release -> all enables 1, flushes 0.
- Load-use: ex_is_load = 1, ex_rd = 5, dec_inst rs = 5 -> exactly 1 cycle of pc_en = 0, fd_en = 0, de_flush = 1. Same with ex_rd = 0 -> no stall.
- Multi-cycle, MC_LAT = 4: dec opcode OP_MUL -> next 3 cycles pc_en = 0 and ex_hold = 1, then RUN resumes with pc_en = 1.
- Branch, BR_PENALTY = 2: br_taken = 1 -> cycle 0 fd_flush = de_flush = 1; cycle 1 fd_flush = 1, de_flush = 0; cycle 2 normal.
- Simultaneous br_taken with load-use, then br_taken with OP_DIV in decode -> flush only, no stall, never enters MC_BUSY.
- Reset mid-MC_BUSY (cycle 2 of 3) -> outputs forced to reset values; after release, state RUN with no residual hold. With PIPE_PERF_CNT_EN, stall_cycles counts exactly the observed pc_en = 0 cycles.
